// File: rtl/ram_responder_if.sv
// ram_responder_if
//   Strobe bus between the CPU control unit (master) and the word-addressed
//   memory responder (slave).
//   master -> slave : ram_cs, ram_we, ram_oe, addr[31:0], wdata[31:0]
//   slave -> master : rdata[31:0], ram_ready, ram_err, ram_busy
interface ram_responder_if;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ram_ready;
  logic        ram_err;
  logic        ram_busy;

  modport master (
    output ram_cs, ram_we, ram_oe, addr, wdata,
    input  rdata, ram_ready, ram_err, ram_busy
  );

  modport slave (
    input  ram_cs, ram_we, ram_oe, addr, wdata,
    output rdata, ram_ready, ram_err, ram_busy
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder
//   Word-addressed 32-bit memory answering the ram_cs/ram_we/ram_oe strobe bus.
//   One request is handled at a time: IDLE accepts, WAIT burns WAIT_CYCLES
//   edges and then performs the access, DONE shows a one-cycle ram_ready
//   (with ram_err for illegal requests).
//   Ports:
//     clk  - single rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - ram_responder_if.slave (strobes, address, data, ready/err/busy)
module ram_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  ram_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_is_write;
  logic          r_is_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic w_accept;
  logic w_access;
  logic w_req_err;
  logic w_mem_we;
  logic w_ready;
  logic w_err;
  logic w_busy;

  // Illegal if the op is ambiguous (both or neither strobe), misaligned, or
  // beyond the array; the word compare uses the full upper address so aliases
  // above the array are rejected rather than wrapped.
  assign w_req_err = (bus.ram_we == bus.ram_oe) ||
                     (bus.addr[1:0] != 2'b00) ||
                     ({2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS));

  assign w_accept = (r_state == ST_IDLE) && bus.ram_cs;
  assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  // rst is checked here as well so a reset on the access edge suppresses the write.
  assign w_mem_we = !rst && w_access && r_is_write && !r_is_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.ram_cs) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'h0;
      r_is_write <= 1'b0;
      r_is_err   <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      if (w_accept) begin
        r_cnt      <= 4'(WAIT_CYCLES);
        r_idx      <= bus.addr[AW+1:2];
        r_wdata    <= bus.wdata;
        r_is_write <= bus.ram_we;
        r_is_err   <= w_req_err;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // A completed write leaves rdata holding the last read/error value.
      if (w_access) begin
        if (r_is_err) begin
          r_rdata <= 32'h0;
        end else if (!r_is_write) begin
          r_rdata <= r_mem[r_idx];
        end
      end
    end
  end

  // Memory array write port (array contents are not reset).
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    w_ready = 1'b0;
    w_err   = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b0;
        w_err   = 1'b0;
        w_busy  = 1'b0;
      end
      ST_WAIT: begin
        w_ready = 1'b0;
        w_err   = 1'b0;
        w_busy  = 1'b1;
      end
      ST_DONE: begin
        w_ready = 1'b1;
        w_err   = r_is_err;
        w_busy  = 1'b1;
      end
      default: begin
        w_ready = 1'b0;
        w_err   = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign bus.rdata     = r_rdata;
  assign bus.ram_ready = w_ready;
  assign bus.ram_err   = w_err;
  assign bus.ram_busy  = w_busy;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
//   Randomized and directed stimulus against ram_responder with a scoreboard:
//   each issued request pushes its expected completion (data, error flag and
//   completion cycle) into a queue; a monitor pops and compares on every
//   ram_ready pulse.
module tb_ram_responder;
  localparam int DEPTH = 64;
  localparam int W     = 3;

  logic clk = 1'b0;
  logic rst;

  ram_responder_if bus_if();

  ram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata = 32'h0;
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_err    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: classify, update the memory model, and predict the
  // completion seen W+1 edges after the accept edge.
  function automatic exp_t predict(input logic we, input logic oe,
                                   input logic [31:0] a, input logic [31:0] d, input int acc);
    exp_t e;
    logic [31:0] word;
    word  = a / 32'd4;
    e.cyc = acc + 1 + W;
    if ((we == oe) || (a % 32'd4 != 32'd0) || (word >= 32'(DEPTH))) begin
      model_rdata = 32'h0;
      e.err       = 1'b1;
    end else if (we) begin
      model_mem[word] = d;
      e.err           = 1'b0;
    end else begin
      model_rdata = model_mem[word];
      e.err       = 1'b0;
    end
    e.rdata = model_rdata;
    return e;
  endfunction

  // Issue one request from IDLE, scramble the inputs after accept, and wait
  // for completion. With rst_mid the request is aborted by a reset one cycle
  // after accept.
  task automatic issue(input logic we, input logic oe, input logic [31:0] a,
                       input logic [31:0] d, input bit rst_mid);
    bit seen;
    check("idle_busy", 32'(bus_if.ram_busy), 32'd0);
    bus_if.ram_cs = 1'b1;
    bus_if.ram_we = we;
    bus_if.ram_oe = oe;
    bus_if.addr   = a;
    bus_if.wdata  = d;
    if (!rst_mid) sb_q.push_back(predict(we, oe, a, d, cyc + 1));
    @(posedge clk); #1;
    check("accept_busy", 32'(bus_if.ram_busy), 32'd1);
    bus_if.ram_cs = 1'($urandom_range(0, 1));
    bus_if.ram_we = 1'($urandom_range(0, 1));
    bus_if.ram_oe = 1'($urandom_range(0, 1));
    bus_if.addr   = $urandom;
    bus_if.wdata  = $urandom;
    if (rst_mid) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus_if.ram_cs = 1'b0;
      model_rdata   = 32'h0;
      check("rst_busy",  32'(bus_if.ram_busy),  32'd0);
      check("rst_ready", 32'(bus_if.ram_ready), 32'd0);
      check("rst_err",   32'(bus_if.ram_err),   32'd0);
      check("rst_rdata", bus_if.rdata,          32'h0);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < W + 6 && !seen; i++) begin
        @(negedge clk);
        seen = bus_if.ram_ready;
      end
      if (!seen) begin
        n_checks++;
        n_err++;
        $display("FAIL ready_timeout: got no ram_ready expected one within %0d cycles", W + 6);
      end
      @(posedge clk); #1;
      bus_if.ram_cs = 1'b0;
      bus_if.ram_we = 1'b0;
      bus_if.ram_oe = 1'b0;
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus_if.ram_err === 1'b1 && bus_if.ram_ready !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL err_without_ready: got ram_err=1 ram_ready=%b expected ram_ready=1", bus_if.ram_ready);
    end
    if (bus_if.ram_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_ready: got ram_ready=1 at cycle %0d expected no pulse", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("rdata",   bus_if.rdata,          mon_e.rdata);
        check("err",     32'(bus_if.ram_err),   32'(mon_e.err));
        check("latency", 32'(cyc),              32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          e0;
    int          r;
    logic        we, oe;
    logic [31:0] a, d;

    rst           = 1'b1;
    bus_if.ram_cs = 1'b0;
    bus_if.ram_we = 1'b0;
    bus_if.ram_oe = 1'b0;
    bus_if.addr   = 32'h0;
    bus_if.wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_busy",  32'(bus_if.ram_busy),  32'd0);
    check("reset_ready", 32'(bus_if.ram_ready), 32'd0);
    check("reset_err",   32'(bus_if.ram_err),   32'd0);
    check("reset_rdata", bus_if.rdata,          32'h0);

    // Give every word a known value so later reads never see X.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0);

    // Directed: write/read, error cases, boundary word.
    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 32'h12, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 32'h10, 32'h11111111, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h22222222, 1'b0);
    issue(1'b1, 1'b0, 32'(DEPTH * 4), 32'h33333333, 1'b0);
    issue(1'b0, 1'b1, 32'(DEPTH * 4 - 4), 32'h0, 1'b0);
    issue(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);

    // Reset one cycle after accepting a write: the write must be lost.
    issue(1'b1, 1'b0, 32'h20, 32'h12345678, 1'b1);
    issue(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);

    // Back-to-back reads with ram_cs held: accepts every W+3 cycles and
    // ram_busy low only in the IDLE cycle between requests.
    e0            = cyc + 1;
    bus_if.ram_cs = 1'b1;
    bus_if.ram_we = 1'b0;
    bus_if.ram_oe = 1'b1;
    bus_if.addr   = 32'h10;
    for (int k = 0; k < 4; k++) sb_q.push_back(predict(1'b0, 1'b1, 32'h10, 32'h0, e0 + k * (W + 3)));
    for (int c = 0; c < 3 * (W + 3) + 2; c++) begin
      @(negedge clk);
      if (cyc >= e0) check("b2b_busy", 32'(bus_if.ram_busy), 32'(((cyc - e0) % (W + 3)) != (W + 2)));
    end
    bus_if.ram_cs = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;

    // Randomized mix of legal and illegal requests.
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 10);
      a  = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      d  = $urandom;
      we = 1'($urandom_range(0, 1));
      oe = !we;
      if (r == 8) a = a + 32'($urandom_range(1, 3));
      else if (r == 9) oe = we;
      else if (r == 10) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 32'd4;
      issue(we, oe, a, d, 1'b0);
    end

    repeat (W + 4) @(posedge clk);
    #1;
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
